mdp3_packet_builder: RTL and testbench

Transmit-side counterpart of the packetizer: accepts one book-update request (security, price, quantity, orders, action, entry type), serializes it into a 37-byte MDP3 incremental-refresh message, and drives it as five 64-bit beats with start_packet/end_packet framing. It is the same word stream the packetizer consumes. It feeds the packetizer input in loopback benches and provides the market-data replay source for the order-book pipeline.

---
 rtl/mdp3_packet_builder.sv | 183 ++++++++++++++++++
 tb/tb_mdp3_packet_builder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdp3_packet_builder.sv
// MDP3 incremental-refresh message builder: serializes one book-update request
// into a 37-byte message driven as five 64-bit beats with packet framing.
module mdp3_packet_builder #(
   parameter int          GAP_CYCLES   = 6,
   parameter logic [31:0] SEQ_INIT     = 32'h021CC2C0,
   parameter logic [31:0] RPT_SEQ_INIT = 32'h0000000C
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] SECURITY_ID,
   input  logic [63:0] PRICE,
   input  logic [15:0] QUANTITY,
   input  logic [7:0]  NUM_ORDERS,
   input  logic [1:0]  ACTION,
   input  logic [1:0]  ENTRY_TYPE,
   output logic [63:0] data_in_out,
   output logic        data_valid,
   output logic        start_packet,
   output logic        end_packet
);

   typedef enum logic [1:0] {S_GAP, S_IDLE, S_SEND} state_t;

   localparam state_t      RESET_STATE = (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
   localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  beat_q, beat_d;
   logic [15:0] gap_q, gap_d;
   logic [31:0] seq_q, seq_d;
   logic [31:0] rpt_q, rpt_d;
   logic [31:0] sec_q, sec_d;
   logic [63:0] price_q, price_d;
   logic [15:0] qty_q, qty_d;
   logic [7:0]  ord_q, ord_d;
   logic [1:0]  act_q, act_d;
   logic [1:0]  ent_q, ent_d;
   logic [63:0] dout_q, dout_d;
   logic        dvalid_q, dvalid_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic        ready_q, ready_d;
   logic [295:0] msg;

   function automatic logic [15:0] bswap16(input logic [15:0] x);
      return {x[7:0], x[15:8]};
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [63:0] bswap64(input logic [63:0] x);
      return {bswap32(x[31:0]), bswap32(x[63:32])};
   endfunction

   // Byte 0 of the message lands in the top byte of the vector.
   function automatic logic [295:0] build_msg(
      input logic [31:0] seq, input logic [31:0] rpt, input logic [31:0] sec,
      input logic [63:0] price, input logic [15:0] qty, input logic [7:0] ord,
      input logic [1:0] act, input logic [1:0] ent);
      return {bswap32(seq), 64'h3D01000068038001, 6'b0, act, 6'b0, ent,
              bswap32(sec), bswap32(rpt), bswap64(price), bswap16(qty),
              ord, 8'hC9, 24'h000000};
   endfunction

   function automatic logic [63:0] beat_sel(input logic [295:0] m, input logic [2:0] k);
      logic [63:0] b;
      case (k)
         3'd0:    b = m[295:232];
         3'd1:    b = m[231:168];
         3'd2:    b = m[167:104];
         3'd3:    b = m[103:40];
         3'd4:    b = {m[39:0], 24'h000000};
         default: b = 64'h0;
      endcase
      return b;
   endfunction

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      gap_d    = gap_q;
      seq_d    = seq_q;
      rpt_d    = rpt_q;
      sec_d    = sec_q;
      price_d  = price_q;
      qty_d    = qty_q;
      ord_d    = ord_q;
      act_d    = act_q;
      ent_d    = ent_q;
      dout_d   = 64'h0;
      dvalid_d = 1'b0;
      sop_d    = 1'b1;
      eop_d    = 1'b0;
      msg      = '0;

      case (state_q)
         S_GAP: begin
            gap_d = gap_q - 16'd1;
            if (gap_q <= 16'd1) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (req_valid) begin
               sec_d   = SECURITY_ID;
               price_d = PRICE;
               qty_d   = QUANTITY;
               ord_d   = NUM_ORDERS;
               act_d   = ACTION;
               ent_d   = ENTRY_TYPE;
               beat_d  = 3'd0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (beat_q == 3'd4) begin
               seq_d   = seq_q + 32'd1;
               rpt_d   = rpt_q + 32'd1;
               gap_d   = GAP_LOAD;
               state_d = RESET_STATE;
            end else begin
               beat_d = beat_q + 3'd1;
            end
         end
         default: state_d = RESET_STATE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      if (state_d == S_SEND) begin
         msg      = build_msg(seq_q, rpt_q, sec_d, price_d, qty_d, ord_d, act_d, ent_d);
         dout_d   = beat_sel(msg, beat_d);
         dvalid_d = 1'b1;
         sop_d    = 1'b0;
         eop_d    = (beat_d == 3'd4);
      end
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= RESET_STATE;
         beat_q   <= 3'd0;
         gap_q    <= GAP_LOAD;
         seq_q    <= SEQ_INIT;
         rpt_q    <= RPT_SEQ_INIT;
         dout_q   <= 64'h0;
         dvalid_q <= 1'b0;
         sop_q    <= 1'b1;
         eop_q    <= 1'b0;
         ready_q  <= (RESET_STATE == S_IDLE);
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         gap_q    <= gap_d;
         seq_q    <= seq_d;
         rpt_q    <= rpt_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         sop_q    <= sop_d;
         eop_q    <= eop_d;
         ready_q  <= ready_d;
      end
   end

   // Holding registers are only meaningful once a request has been accepted.
   always_ff @(posedge clk) begin
      sec_q   <= sec_d;
      price_q <= price_d;
      qty_q   <= qty_d;
      ord_q   <= ord_d;
      act_q   <= act_d;
      ent_q   <= ent_d;
   end

   assign req_ready    = ready_q;
   assign data_in_out  = dout_q;
   assign data_valid   = dvalid_q;
   assign start_packet = sop_q;
   assign end_packet   = eop_q;

endmodule

// File: tb/tb_mdp3_packet_builder.sv
// Bench for mdp3_packet_builder: directed and random requests against a
// byte-level message model, plus reset and sequence-wrap scenarios.
module tb_mdp3_packet_builder;

   localparam logic [31:0] SEQ_INIT  = 32'h021CC2C0;
   localparam logic [31:0] RPT_INIT  = 32'h0000000C;
   localparam logic [31:0] SEQ2_INIT = 32'hFFFFFFFF;

   typedef struct packed {
      logic [31:0] sec;
      logic [63:0] pr;
      logic [15:0] q;
      logic [7:0]  no;
      logic [1:0]  ac;
      logic [1:0]  et;
   } req_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready, req_ready2;
   logic [31:0] SECURITY_ID;
   logic [63:0] PRICE;
   logic [15:0] QUANTITY;
   logic [7:0]  NUM_ORDERS;
   logic [1:0]  ACTION;
   logic [1:0]  ENTRY_TYPE;
   logic [63:0] data_in_out, data_in_out2;
   logic        data_valid, data_valid2;
   logic        start_packet, start_packet2;
   logic        end_packet, end_packet2;

   int          checks = 0;
   int          failures = 0;
   int          sop_run = 0;
   logic [31:0] m_seq, m_rpt, m_seq2;

   always #5 clk = ~clk;

   mdp3_packet_builder dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .SECURITY_ID(SECURITY_ID), .PRICE(PRICE), .QUANTITY(QUANTITY),
      .NUM_ORDERS(NUM_ORDERS), .ACTION(ACTION), .ENTRY_TYPE(ENTRY_TYPE),
      .data_in_out(data_in_out), .data_valid(data_valid),
      .start_packet(start_packet), .end_packet(end_packet));

   mdp3_packet_builder #(.SEQ_INIT(SEQ2_INIT)) dut2 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready2),
      .SECURITY_ID(SECURITY_ID), .PRICE(PRICE), .QUANTITY(QUANTITY),
      .NUM_ORDERS(NUM_ORDERS), .ACTION(ACTION), .ENTRY_TYPE(ENTRY_TYPE),
      .data_in_out(data_in_out2), .data_valid(data_valid2),
      .start_packet(start_packet2), .end_packet(end_packet2));

   // Message byte i as laid out on the wire (little-endian fields).
   function automatic logic [7:0] mbyte(input int i, input req_t r,
                                        input logic [31:0] sq, input logic [31:0] rp);
      logic [63:0] hdr;
      hdr = 64'h3D01000068038001;
      if (i < 4)       return sq[8*i +: 8];
      else if (i < 12) return hdr[8*(11-i) +: 8];
      else if (i == 12) return {6'b0, r.ac};
      else if (i == 13) return {6'b0, r.et};
      else if (i < 18) return r.sec[8*(i-14) +: 8];
      else if (i < 22) return rp[8*(i-18) +: 8];
      else if (i < 30) return r.pr[8*(i-22) +: 8];
      else if (i < 32) return r.q[8*(i-30) +: 8];
      else if (i == 32) return r.no;
      else if (i == 33) return 8'hC9;
      return 8'h00;
   endfunction

   function automatic logic [63:0] exp_beat(input int k, input req_t r,
                                            input logic [31:0] sq, input logic [31:0] rp);
      logic [63:0] b;
      for (int j = 0; j < 8; j++) b[63-8*j -: 8] = mbyte(8*k + j, r, sq, rp);
      return b;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.sec = $urandom;
      r.pr  = {$urandom, $urandom};
      r.q   = 16'($urandom);
      r.no  = 8'($urandom);
      r.ac  = 2'($urandom);
      r.et  = 2'($urandom);
      return r;
   endfunction

   task automatic drive(input req_t r);
      SECURITY_ID = r.sec;
      PRICE       = r.pr;
      QUANTITY    = r.q;
      NUM_ORDERS  = r.no;
      ACTION      = r.ac;
      ENTRY_TYPE  = r.et;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic out_chk(input string tag, input logic rdy, input logic sop,
                          input logic dv, input logic eop, input logic [63:0] data);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'(rdy));
      chk({tag, ".start_packet"}, 64'(start_packet), 64'(sop));
      chk({tag, ".data_valid"}, 64'(data_valid), 64'(dv));
      chk({tag, ".end_packet"}, 64'(end_packet), 64'(eop));
      chk({tag, ".data"}, data_in_out, data);
      if (start_packet) sop_run++;
      else sop_run = 0;
   endtask

   task automatic reset_values(input string tag);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, ".start_packet"}, 64'(start_packet), 64'd1);
      chk({tag, ".data_valid"}, 64'(data_valid), 64'd0);
      chk({tag, ".end_packet"}, 64'(end_packet), 64'd0);
      chk({tag, ".data"}, data_in_out, 64'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 reset_n = 1'b1;
      m_seq   = SEQ_INIT;
      m_rpt   = RPT_INIT;
      m_seq2  = SEQ2_INIT;
      sop_run = 0;
   endtask

   // Idle cycles where the builder must ignore a pending request.
   task automatic gap_cycles(input string tag);
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         drive(rand_req());
         req_valid = 1'b1;
         out_chk(tag, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
      end
   endtask

   // Accept cycle, beats (up to last_beat), and optional post-packet gap.
   task automatic send_packet(input req_t r, input int last_beat, output logic [319:0] cat);
      logic [63:0] eb;
      cat = '0;
      @(negedge clk);
      drive(r);
      req_valid = 1'b1;
      out_chk("accept", 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
      for (int k = 0; k <= last_beat; k++) begin
         @(negedge clk);
         drive(rand_req());
         req_valid = 1'($urandom);
         if (k == 0) chk("sop_gap_len", 64'(sop_run), 64'd6);
         eb = exp_beat(k, r, m_seq, m_rpt);
         out_chk($sformatf("beat%0d", k), 1'b0, 1'b0, 1'b1, k == 4, eb);
         cat[319-64*k -: 64] = data_in_out;
         if (k == 0) chk("dut2.beat0", data_in_out2, exp_beat(0, r, m_seq2, m_rpt));
      end
      if (last_beat == 4) begin
         m_seq  = m_seq + 32'd1;
         m_rpt  = m_rpt + 32'd1;
         m_seq2 = m_seq2 + 32'd1;
         gap_cycles("gap");
      end
   endtask

   initial begin
      logic [319:0] cat;
      logic [295:0] lit;
      req_t         r;

      reset_n   = 1'b0;
      req_valid = 1'b1;
      drive(rand_req());
      repeat (3) @(posedge clk);
      #1 reset_values("in_reset");
      release_reset();
      gap_cycles("post_reset");

      r = '{sec: 32'd123, pr: 64'd9, q: 16'h00AE, no: 8'd1, ac: 2'd0, et: 2'd0};
      send_packet(r, 4, cat);
      lit = 296'hC0C21C023D0100006803800100007B0000000C0000000900000000000000AE0001C9000000;
      checks++;
      assert (cat[319:24] === lit)
      else begin
         failures++;
         $error("FAIL msg296 observed=%h expected=%h", cat[319:24], lit);
      end
      chk("msg_pad", 64'(cat[23:0]), 64'd0);

      r = '{sec: 32'd123, pr: 64'd5, q: 16'd5, no: 8'd2, ac: 2'd1, et: 2'd0};
      send_packet(r, 4, cat);
      chk("pkt2.seq", 64'(cat[319:288]), 64'h00000000C1C21C02);
      chk("pkt2.rpt", 64'(cat[175:168]), 64'h0D);

      for (int p = 0; p < 6; p++) send_packet(rand_req(), 4, cat);

      send_packet(rand_req(), 2, cat);
      #1 reset_n = 1'b0;
      #1 reset_values("mid_reset");
      release_reset();
      gap_cycles("post_reset2");
      send_packet(rand_req(), 4, cat);
      chk("reset_seq", 64'(cat[319:288]), 64'h00000000C0C21C02);
      send_packet(rand_req(), 4, cat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
